// File: rtl/trace_scheduler.sv
// Per-frame sequencer for the column ray tracer: snapshots the host camera set and gates
// the tracer into the VBLANK window. Optional cycle statistics under TRACE_SCHED_STATS_EN.
module trace_scheduler #(
  parameter int FW               = 16,
  parameter int TRACE_START_LINE = 480,
  parameter int TRACE_END_LINE   = 524,
  parameter int H_LAST           = 799,
  parameter int LAST_COL         = 639,
  parameter int CYC_W            = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [9:0]       hpos,
  input  logic [9:0]       vpos,
  input  logic [FW-1:0]    host_px,
  input  logic [FW-1:0]    host_py,
  input  logic [FW-1:0]    host_fx,
  input  logic [FW-1:0]    host_fy,
  input  logic [FW-1:0]    host_vx,
  input  logic [FW-1:0]    host_vy,
  input  logic             host_commit,
  input  logic             overrun_clr,
  input  logic             trace_store,
  input  logic [9:0]       trace_column,
  output logic             trace_en,
  output logic [FW-1:0]    playerX,
  output logic [FW-1:0]    playerY,
  output logic [FW-1:0]    facingX,
  output logic [FW-1:0]    facingY,
  output logic [FW-1:0]    vplaneX,
  output logic [FW-1:0]    vplaneY,
  output logic [10:0]      frame_count,
  output logic             trace_done,
  output logic             overrun,
`ifdef TRACE_SCHED_STATS_EN
  output logic [CYC_W-1:0] last_cycles,
  output logic [CYC_W-1:0] max_cycles,
`endif
  output logic             pending_valid
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    DONE  = 3'd3,
    ABORT = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [5:0][FW-1:0]   pend_q, pend_d;
  logic [5:0][FW-1:0]   act_q, act_d;
  logic [5:0][FW-1:0]   host_vec;
  logic                 pend_valid_q, pend_valid_d;
  logic [10:0]          frame_q, frame_d;
  logic                 trace_en_q, trace_en_d;
  logic                 trace_done_q, trace_done_d;
  logic                 overrun_q, overrun_d;
  logic                 start_evt, end_evt, done_hit;

  // Vector slots: 0=px 1=py 2=fx 3=fy 4=vx 5=vy
  assign host_vec = {host_vy, host_vx, host_fy, host_fx, host_py, host_px};

  assign start_evt = (vpos == 10'(TRACE_START_LINE)) && (hpos == 10'd0);
  assign end_evt   = (vpos == 10'(TRACE_END_LINE)) && (hpos == 10'(H_LAST));
  assign done_hit  = trace_store && (trace_column == 10'(LAST_COL));

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    act_d        = act_q;
    frame_d      = frame_q;
    case (state_q)
      IDLE: begin
        if (start_evt) state_d = LOAD;
        else           state_d = IDLE;
      end
      LOAD: begin
        if (pend_valid_q) begin
          act_d        = pend_q;
          pend_valid_d = 1'b0;
        end else begin
          act_d        = act_q;
        end
        frame_d = frame_q + 11'd1;
        state_d = RUN;
      end
      RUN: begin
        // Completion takes priority over the window closing in the same cycle.
        if (done_hit)     state_d = DONE;
        else if (end_evt) state_d = ABORT;
        else              state_d = RUN;
      end
      DONE:    state_d = IDLE;
      ABORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A commit in LOAD lands after the snapshot above, so it waits for the next frame.
    if (host_commit) begin
      pend_d       = host_vec;
      pend_valid_d = 1'b1;
    end else begin
      pend_d       = pend_d;
    end

    trace_en_d   = (state_d == RUN);
    trace_done_d = (state_d == DONE);

    overrun_d = overrun_q;
    if (state_d == ABORT)  overrun_d = 1'b1;
    else if (overrun_clr)  overrun_d = 1'b0;
    else                   overrun_d = overrun_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      act_q        <= '0;
      frame_q      <= 11'd0;
      trace_en_q   <= 1'b0;
      trace_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      act_q        <= act_d;
      frame_q      <= frame_d;
      trace_en_q   <= trace_en_d;
      trace_done_q <= trace_done_d;
      overrun_q    <= overrun_d;
    end
  end

`ifdef TRACE_SCHED_STATS_EN
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [CYC_W-1:0] last_q, last_d;
  logic [CYC_W-1:0] max_q, max_d;

  always_comb begin
    cyc_d  = cyc_q;
    last_d = last_q;
    max_d  = max_q;
    if (state_q == LOAD)                     cyc_d = '0;
    else if (state_q == RUN && cyc_q != '1)  cyc_d = cyc_q + CYC_W'(1);
    else                                     cyc_d = cyc_q;

    if (state_q == DONE) begin
      last_d = cyc_q;
      if (overrun_clr || (cyc_q > max_q)) max_d = cyc_q;
      else                                max_d = max_q;
    end else if (overrun_clr) begin
      max_d = '0;
    end else begin
      max_d = max_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_q  <= '0;
      last_q <= '0;
      max_q  <= '0;
    end else begin
      cyc_q  <= cyc_d;
      last_q <= last_d;
      max_q  <= max_d;
    end
  end

  assign last_cycles = last_q;
  assign max_cycles  = max_q;
`endif

  assign trace_en      = trace_en_q;
  assign trace_done    = trace_done_q;
  assign overrun       = overrun_q;
  assign pending_valid = pend_valid_q;
  assign frame_count   = frame_q;
  assign playerX       = act_q[0];
  assign playerY       = act_q[1];
  assign facingX       = act_q[2];
  assign facingY       = act_q[3];
  assign vplaneX       = act_q[4];
  assign vplaneY       = act_q[5];

endmodule
